// File: rtl/ccu_snoop_fanout.sv
// ccu_snoop_fanout: broadcasts one AC snoop to the cached masters selected by a
// domain mask, merges their CR responses into one, forwards one master's CD
// stream and drains CD from any other master that also returns data.
// Optional feature macro: CCU_SNOOP_FANOUT_DIRTY_PRIO_EN -- when defined, a master
// answering PassDirty|DataTransfer is preferred as the CD source.

// Per-master handshake gating; one instance per cached master.
module ccu_snoop_fanout_lane (
  input  logic i_fanout,
  input  logic i_cr_phase,
  input  logic i_data,
  input  logic i_is_src,
  input  logic i_ac_pend,
  input  logic i_cr_pend,
  input  logic i_cd_pend,
  input  logic i_ac_ready,
  input  logic i_cr_valid,
  input  logic i_cd_valid,
  input  logic i_cd_last,
  input  logic i_cd_ready_up,
  output logic o_ac_valid,
  output logic o_ac_hs,
  output logic o_cr_ready,
  output logic o_cr_hs,
  output logic o_cd_ready,
  output logic o_cd_done
);
  // CR may be taken once this master's AC is done, including an AC handshake
  // happening this very cycle; non-source CD is always drained.
  always_comb begin
    o_ac_valid = i_fanout & i_ac_pend;
    o_ac_hs    = o_ac_valid & i_ac_ready;
    o_cr_ready = i_cr_phase & i_cr_pend & ~(i_ac_pend & ~o_ac_hs);
    o_cr_hs    = o_cr_ready & i_cr_valid;
    o_cd_ready = i_data & i_cd_pend & (i_is_src ? i_cd_ready_up : 1'b1);
    o_cd_done  = o_cd_ready & i_cd_valid & i_cd_last;
  end
endmodule

module ccu_snoop_fanout #(
  parameter int unsigned NoMst     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  input  logic [2:0]                 ac_prot_i,
  input  logic [NoMst-1:0]           domain_mask_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [DataWidth-1:0]       cd_data_o,
  output logic                       cd_last_o,
  output logic [NoMst-1:0]           mst_ac_valid_o,
  input  logic [NoMst-1:0]           mst_ac_ready_i,
  output logic [AddrWidth-1:0]       mst_ac_addr_o,
  output logic [3:0]                 mst_ac_snoop_o,
  output logic [2:0]                 mst_ac_prot_o,
  input  logic [NoMst-1:0]           mst_cr_valid_i,
  output logic [NoMst-1:0]           mst_cr_ready_o,
  input  logic [5*NoMst-1:0]         mst_cr_resp_i,
  input  logic [NoMst-1:0]           mst_cd_valid_i,
  output logic [NoMst-1:0]           mst_cd_ready_o,
  input  logic [DataWidth*NoMst-1:0] mst_cd_data_i,
  input  logic [NoMst-1:0]           mst_cd_last_i
);
  localparam int unsigned SrcW = (NoMst > 1) ? $clog2(NoMst) : 1;

  typedef enum logic [2:0] {IDLE, FANOUT, COLLECT, RESP, DATA} state_e;

  state_e                        r_state, w_state_nxt;
  logic [AddrWidth-1:0]          r_addr;
  logic [3:0]                    r_snoop;
  logic [2:0]                    r_prot;
  logic [NoMst-1:0]              r_ac_pend, r_cr_pend, r_cd_pend;
  logic [NoMst-1:0]              w_ac_pend_nxt, w_cr_pend_nxt, w_cd_pend_nxt;
  logic [4:0]                    r_resp, w_resp_or;
  logic [SrcW-1:0]               r_src, w_src_nxt;
  logic                          r_src_vld, w_src_vld_nxt;
  logic                          r_src_dirty, w_src_dirty_nxt, w_cand_dirty;
  logic [NoMst-1:0]              w_ac_hs, w_cr_hs, w_cd_done, w_cd_set;
  logic [NoMst-1:0][4:0]         w_cr_resp;
  logic [NoMst-1:0][DataWidth-1:0] w_cd_data;
  logic                          w_fanout, w_cr_phase, w_data, w_ac_acc;

  assign w_cr_resp  = mst_cr_resp_i;
  assign w_cd_data  = mst_cd_data_i;
  assign w_fanout   = (r_state == FANOUT);
  assign w_cr_phase = (r_state == FANOUT) || (r_state == COLLECT);
  assign w_data     = (r_state == DATA);
  assign w_ac_acc   = (r_state == IDLE) && ac_valid_i;

  assign mst_ac_addr_o  = r_addr;
  assign mst_ac_snoop_o = r_snoop;
  assign mst_ac_prot_o  = r_prot;

  for (genvar g = 0; g < NoMst; g++) begin : g_lane
    ccu_snoop_fanout_lane u_lane (
      .i_fanout      (w_fanout),
      .i_cr_phase    (w_cr_phase),
      .i_data        (w_data),
      .i_is_src      (r_src == SrcW'(g)),
      .i_ac_pend     (r_ac_pend[g]),
      .i_cr_pend     (r_cr_pend[g]),
      .i_cd_pend     (r_cd_pend[g]),
      .i_ac_ready    (mst_ac_ready_i[g]),
      .i_cr_valid    (mst_cr_valid_i[g]),
      .i_cd_valid    (mst_cd_valid_i[g]),
      .i_cd_last     (mst_cd_last_i[g]),
      .i_cd_ready_up (cd_ready_i),
      .o_ac_valid    (mst_ac_valid_o[g]),
      .o_ac_hs       (w_ac_hs[g]),
      .o_cr_ready    (mst_cr_ready_o[g]),
      .o_cr_hs       (w_cr_hs[g]),
      .o_cd_ready    (mst_cd_ready_o[g]),
      .o_cd_done     (w_cd_done[g])
    );
  end

  // Merge CR responses of this cycle and keep the best CD source seen so far.
  always_comb begin
    w_resp_or       = '0;
    w_cd_set        = '0;
    w_cand_dirty    = 1'b0;
    w_src_nxt       = r_src;
    w_src_vld_nxt   = r_src_vld;
    w_src_dirty_nxt = r_src_dirty;
    for (int i = 0; i < NoMst; i++) begin
      if (w_cr_hs[i]) begin
        w_resp_or |= w_cr_resp[i];
        if (w_cr_resp[i][0]) begin
          w_cd_set[i] = 1'b1;
`ifdef CCU_SNOOP_FANOUT_DIRTY_PRIO_EN
          w_cand_dirty = w_cr_resp[i][2];
`else
          w_cand_dirty = 1'b0;
`endif
          if (!w_src_vld_nxt || (w_cand_dirty && !w_src_dirty_nxt) ||
              ((w_cand_dirty == w_src_dirty_nxt) && (SrcW'(i) < w_src_nxt))) begin
            w_src_nxt       = SrcW'(i);
            w_src_vld_nxt   = 1'b1;
            w_src_dirty_nxt = w_cand_dirty;
          end
        end
      end
    end
  end

  assign w_ac_pend_nxt = r_ac_pend & ~w_ac_hs;
  assign w_cr_pend_nxt = r_cr_pend & ~w_cr_hs;
  assign w_cd_pend_nxt = (r_cd_pend | w_cd_set) & ~w_cd_done;

  // Next state and upstream-facing outputs.
  always_comb begin
    w_state_nxt = r_state;
    ac_ready_o  = 1'b0;
    cr_valid_o  = 1'b0;
    cr_resp_o   = '0;
    cd_valid_o  = 1'b0;
    cd_data_o   = '0;
    cd_last_o   = 1'b0;
    case (r_state)
      IDLE: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) w_state_nxt = (|domain_mask_i) ? FANOUT : RESP;
      end
      FANOUT: begin
        if (~|w_cr_pend_nxt)      w_state_nxt = RESP;
        else if (~|w_ac_pend_nxt) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        if (~|w_cr_pend_nxt) w_state_nxt = RESP;
      end
      RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = r_resp;
        if (cr_ready_i) w_state_nxt = (|r_cd_pend) ? DATA : IDLE;
      end
      DATA: begin
        cd_valid_o = mst_cd_valid_i[r_src] & r_cd_pend[r_src];
        cd_data_o  = w_cd_data[r_src];
        cd_last_o  = mst_cd_last_i[r_src];
        if (~|w_cd_pend_nxt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Captured AC payload, pending vectors, merged response and CD source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_snoop     <= '0;
      r_prot      <= '0;
      r_ac_pend   <= '0;
      r_cr_pend   <= '0;
      r_cd_pend   <= '0;
      r_resp      <= '0;
      r_src       <= '0;
      r_src_vld   <= 1'b0;
      r_src_dirty <= 1'b0;
    end else if (w_ac_acc) begin
      r_addr      <= ac_addr_i;
      r_snoop     <= ac_snoop_i;
      r_prot      <= ac_prot_i;
      r_ac_pend   <= domain_mask_i;
      r_cr_pend   <= domain_mask_i;
      r_cd_pend   <= '0;
      r_resp      <= '0;
      r_src       <= '0;
      r_src_vld   <= 1'b0;
      r_src_dirty <= 1'b0;
    end else begin
      r_ac_pend   <= w_ac_pend_nxt;
      r_cr_pend   <= w_cr_pend_nxt;
      r_cd_pend   <= w_cd_pend_nxt;
      r_resp      <= r_resp | w_resp_or;
      r_src       <= w_src_nxt;
      r_src_vld   <= w_src_vld_nxt;
      r_src_dirty <= w_src_dirty_nxt;
    end
  end
endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Directed bench for ccu_snoop_fanout: zero mask, plain merge, CD forward/drain,
// dirty source priority, staggered fanout with reverse CR order, mid-DATA reset.
module tb_ccu_snoop_fanout;
  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              ac_valid_i, ac_ready_o;
  logic [63:0]       ac_addr_i;
  logic [3:0]        ac_snoop_i;
  logic [2:0]        ac_prot_i;
  logic [3:0]        domain_mask_i;
  logic              cr_valid_o, cr_ready_i;
  logic [4:0]        cr_resp_o;
  logic              cd_valid_o, cd_ready_i, cd_last_o;
  logic [63:0]       cd_data_o;
  logic [3:0]        mst_ac_valid_o, mst_ac_ready_i;
  logic [63:0]       mst_ac_addr_o;
  logic [3:0]        mst_ac_snoop_o;
  logic [2:0]        mst_ac_prot_o;
  logic [3:0]        mst_cr_valid_i, mst_cr_ready_o;
  logic [3:0][4:0]   cr_resp;
  logic [3:0]        mst_cd_valid_i, mst_cd_ready_o, mst_cd_last_i;
  logic [3:0][63:0]  cd_data;

  int nvec = 0;
  int nfail = 0;

`ifdef CCU_SNOOP_FANOUT_DIRTY_PRIO_EN
  localparam int SRC4 = 1;
`else
  localparam int SRC4 = 0;
`endif

  always #5 clk_i = ~clk_i;

  ccu_snoop_fanout #(.NoMst(4), .AddrWidth(64), .DataWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .domain_mask_i(domain_mask_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o),
    .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
    .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
    .mst_ac_prot_o(mst_ac_prot_o),
    .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
    .mst_cr_resp_i(cr_resp),
    .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
    .mst_cd_data_i(cd_data), .mst_cd_last_i(mst_cd_last_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Drives masters 0 and 1 with 4-beat bursts (0xA0.. / 0xB0..), master i starting
  // at cycle dly_i, cd_ready_i low at cycle stall_k; checks forwarding from src.
  task automatic run_data(input int src, input int dly0, input int dly1, input int stall_k);
    int          cnt[2];
    bit          pend[2];
    logic [1:0]  vld, erdy;
    int          dly[2];
    logic [63:0] base[2];
    int          k;
    cnt = '{0, 0}; pend = '{1'b1, 1'b1}; dly = '{dly0, dly1};
    base = '{64'hA0, 64'hB0};
    k = 0;
    while ((pend[0] || pend[1]) && k < 12) begin
      cd_ready_i = (k != stall_k);
      for (int i = 0; i < 2; i++) begin
        vld[i] = pend[i] && (k >= dly[i]);
        cd_data[i] = base[i] + 64'(cnt[i]);
        mst_cd_last_i[i] = (cnt[i] == 3);
      end
      mst_cd_valid_i = {2'b00, vld};
      #1;
      for (int i = 0; i < 2; i++) erdy[i] = pend[i] && ((i == src) ? cd_ready_i : 1'b1);
      chk("cd_ready_fan", {60'd0, mst_cd_ready_o}, {62'd0, erdy});
      chk("cd_valid", {63'd0, cd_valid_o}, {63'd0, vld[src]});
      if (vld[src]) begin
        chk("cd_data", cd_data_o, base[src] + 64'(cnt[src]));
        chk("cd_last", {63'd0, cd_last_o}, {63'd0, (cnt[src] == 3)});
      end
      chk("ac_ready_busy", {63'd0, ac_ready_o}, 64'd0);
      for (int i = 0; i < 2; i++)
        if (vld[i] && erdy[i]) begin
          if (cnt[i] == 3) pend[i] = 1'b0;
          cnt[i]++;
        end
      cyc();
      k++;
    end
    chk("data_done", {62'd0, pend[1], pend[0]}, 64'd0);
    mst_cd_valid_i = '0; mst_cd_last_i = '0; cd_ready_i = 1'b0;
    #1;
    chk("idle_after_data", {63'd0, ac_ready_o}, 64'd1);
    chk("cd_valid_idle", {63'd0, cd_valid_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    domain_mask_i = '0; cr_ready_i = 0; cd_ready_i = 0; mst_ac_ready_i = '0;
    mst_cr_valid_i = '0; cr_resp = '0; mst_cd_valid_i = '0; cd_data = '0;
    mst_cd_last_i = '0;
    #1;
    chk("rst_ac_ready", {63'd0, ac_ready_o}, 64'd1);
    chk("rst_cr_valid", {63'd0, cr_valid_o}, 64'd0);
    chk("rst_mst_ac_valid", {60'd0, mst_ac_valid_o}, 64'd0);
    chk("rst_cd_valid", {63'd0, cd_valid_o}, 64'd0);
    chk("rst_mst_cr_ready", {60'd0, mst_cr_ready_o}, 64'd0);
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();

    // Zero mask: immediate response of 0.
    ac_valid_i = 1; ac_addr_i = 64'h1000; domain_mask_i = 4'b0000;
    #1 chk("t1_ac_ready", {63'd0, ac_ready_o}, 64'd1);
    cyc();
    ac_valid_i = 0;
    #1;
    chk("t1_cr_valid", {63'd0, cr_valid_o}, 64'd1);
    chk("t1_cr_resp", {59'd0, cr_resp_o}, 64'd0);
    chk("t1_no_fanout", {60'd0, mst_ac_valid_o}, 64'd0);
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    #1;
    chk("t1_idle_cr_valid", {63'd0, cr_valid_o}, 64'd0);
    chk("t1_idle_ac_ready", {63'd0, ac_ready_o}, 64'd1);

    // Mask 0101, IsShared from master 0, no data.
    ac_valid_i = 1; ac_addr_i = 64'h2000; ac_snoop_i = 4'h1; ac_prot_i = 3'h2;
    domain_mask_i = 4'b0101;
    cyc();
    ac_valid_i = 0;
    #1;
    chk("t2_mst_ac_valid", {60'd0, mst_ac_valid_o}, 64'h5);
    chk("t2_mst_ac_addr", mst_ac_addr_o, 64'h2000);
    chk("t2_mst_ac_snoop", {60'd0, mst_ac_snoop_o}, 64'h1);
    chk("t2_mst_ac_prot", {61'd0, mst_ac_prot_o}, 64'h2);
    chk("t2_cr_ready_early", {60'd0, mst_cr_ready_o}, 64'd0);
    chk("t2_ac_ready_busy", {63'd0, ac_ready_o}, 64'd0);
    mst_ac_ready_i = 4'b0101;
    cyc();
    mst_ac_ready_i = '0;
    mst_cr_valid_i = 4'b0101; cr_resp[0] = 5'b01000; cr_resp[2] = 5'b00000;
    #1;
    chk("t2_ac_done", {60'd0, mst_ac_valid_o}, 64'd0);
    chk("t2_cr_ready", {60'd0, mst_cr_ready_o}, 64'h5);
    cyc();
    mst_cr_valid_i = '0;
    #1;
    chk("t2_cr_valid", {63'd0, cr_valid_o}, 64'd1);
    chk("t2_cr_resp", {59'd0, cr_resp_o}, 64'h08);
    // Release CR and queue the next AC at once.
    cr_ready_i = 1;
    ac_valid_i = 1; ac_addr_i = 64'h3000; domain_mask_i = 4'b0011;
    cyc();
    cr_ready_i = 0;
    #1 chk("t2_next_ac_ready", {63'd0, ac_ready_o}, 64'd1);

    // Mask 0011, both masters return data; master 0 forwarded, master 1 drained.
    cyc();
    ac_valid_i = 0;
    mst_ac_ready_i = 4'b0011;
    cyc();
    mst_ac_ready_i = '0;
    mst_cr_valid_i = 4'b0011; cr_resp[0] = 5'b00001; cr_resp[1] = 5'b00001;
    cyc();
    mst_cr_valid_i = '0;
    #1;
    chk("t3_cr_valid", {63'd0, cr_valid_o}, 64'd1);
    chk("t3_cr_resp", {59'd0, cr_resp_o}, 64'h01);
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    run_data(0, 0, 1, -1);

    // Master 1 dirty: source depends on the dirty-priority build option.
    ac_valid_i = 1; ac_addr_i = 64'h4000; domain_mask_i = 4'b0011;
    cyc();
    ac_valid_i = 0;
    mst_ac_ready_i = 4'b0011;
    cyc();
    mst_ac_ready_i = '0;
    mst_cr_valid_i = 4'b0011; cr_resp[0] = 5'b00001; cr_resp[1] = 5'b00101;
    cyc();
    mst_cr_valid_i = '0;
    #1;
    chk("t4_cr_resp", {59'd0, cr_resp_o}, 64'h05);
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    run_data(SRC4, 0, 0, 1);

    // All four masters, staggered AC, reverse-order CR.
    ac_valid_i = 1; ac_addr_i = 64'h5000; ac_snoop_i = 4'h7; ac_prot_i = 3'h5;
    domain_mask_i = 4'b1111;
    cyc();
    ac_valid_i = 0;
    mst_ac_ready_i = 4'b0001;
    #1;
    chk("t5_fan0", {60'd0, mst_ac_valid_o}, 64'hF);
    chk("t5_addr", mst_ac_addr_o, 64'h5000);
    cyc();
    mst_ac_ready_i = 4'b0010;
    #1 chk("t5_fan1", {60'd0, mst_ac_valid_o}, 64'hE);
    cyc();
    mst_ac_ready_i = 4'b0100;
    #1 chk("t5_fan2", {60'd0, mst_ac_valid_o}, 64'hC);
    chk("t5_ac_ready_busy", {63'd0, ac_ready_o}, 64'd0);
    cyc();
    mst_ac_ready_i = 4'b1000;
    #1 chk("t5_fan3", {60'd0, mst_ac_valid_o}, 64'h8);
    cyc();
    mst_ac_ready_i = '0;
    cr_resp[3] = 5'b10000; cr_resp[2] = 5'b01000; cr_resp[1] = 5'b00100; cr_resp[0] = 5'b00010;
    mst_cr_valid_i = 4'b1000;
    #1;
    chk("t5_fan_done", {60'd0, mst_ac_valid_o}, 64'd0);
    chk("t5_crr3", {60'd0, mst_cr_ready_o}, 64'hF);
    cyc();
    mst_cr_valid_i = 4'b0100;
    #1 chk("t5_crr2", {60'd0, mst_cr_ready_o}, 64'h7);
    chk("t5_no_resp_yet", {63'd0, cr_valid_o}, 64'd0);
    cyc();
    mst_cr_valid_i = 4'b0010;
    #1 chk("t5_crr1", {60'd0, mst_cr_ready_o}, 64'h3);
    cyc();
    mst_cr_valid_i = 4'b0001;
    #1 chk("t5_crr0", {60'd0, mst_cr_ready_o}, 64'h1);
    cyc();
    mst_cr_valid_i = '0;
    #1;
    chk("t5_cr_valid", {63'd0, cr_valid_o}, 64'd1);
    chk("t5_cr_resp", {59'd0, cr_resp_o}, 64'h1E);
    chk("t5_ac_ready_resp", {63'd0, ac_ready_o}, 64'd0);
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    #1 chk("t5_idle", {63'd0, ac_ready_o}, 64'd1);

    // Reset in the middle of DATA while the source is stalled.
    ac_valid_i = 1; ac_addr_i = 64'h6000; domain_mask_i = 4'b0001;
    cyc();
    ac_valid_i = 0;
    mst_ac_ready_i = 4'b0001;
    cyc();
    mst_ac_ready_i = '0;
    mst_cr_valid_i = 4'b0001; cr_resp[0] = 5'b00001;
    cyc();
    mst_cr_valid_i = '0;
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    mst_cd_valid_i = 4'b0001; cd_data[0] = 64'hCC; cd_ready_i = 0;
    #1;
    chk("t6_cd_valid", {63'd0, cd_valid_o}, 64'd1);
    chk("t6_cd_data", cd_data_o, 64'hCC);
    chk("t6_cd_ready_stall", {60'd0, mst_cd_ready_o}, 64'd0);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_cd_valid", {63'd0, cd_valid_o}, 64'd0);
    chk("t6_rst_ac_ready", {63'd0, ac_ready_o}, 64'd1);
    chk("t6_rst_cr_valid", {63'd0, cr_valid_o}, 64'd0);
    chk("t6_rst_cd_ready", {60'd0, mst_cd_ready_o}, 64'd0);
    mst_cd_valid_i = '0;
    cyc();
    rst_ni = 1'b1;
    ac_valid_i = 1; ac_addr_i = 64'h7000; domain_mask_i = 4'b0010;
    #1 chk("t6_fresh_ac_ready", {63'd0, ac_ready_o}, 64'd1);
    cyc();
    ac_valid_i = 0;
    #1;
    chk("t6_fresh_fan", {60'd0, mst_ac_valid_o}, 64'h2);
    chk("t6_fresh_addr", mst_ac_addr_o, 64'h7000);
    mst_ac_ready_i = 4'b0010;
    cyc();
    mst_ac_ready_i = '0;
    mst_cr_valid_i = 4'b0010; cr_resp[1] = 5'b00000;
    cyc();
    mst_cr_valid_i = '0;
    #1;
    chk("t6_cr_valid", {63'd0, cr_valid_o}, 64'd1);
    chk("t6_cr_resp", {59'd0, cr_resp_o}, 64'd0);
    cr_ready_i = 1;
    cyc();
    cr_ready_i = 0;
    #1 chk("t6_idle", {63'd0, ac_ready_o}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
